// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan scheduler for a common-anode multi-digit 7-seg display
//
// Ports:
//   Clk        in   system clock, rising edge
//   Rst_n      in   asynchronous reset, active-low
//   Digits     in   BCD digits, [3:0] = digit 0 (least significant)
//   DigitEn    in   per-digit enable, 0 = digit never lit
//   LzbEn      in   leading-zero blanking enable
//   BCD        out  digit code for the shared registered decoder
//   An         out  anode drive, active-low, at most one bit low
//   DigitIdx   out  index of the current digit slot
//   FrameDone  out  one-cycle pulse on the last cycle of the last slot
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic [4*NUM_DIGITS-1:0]       Digits,
    input  logic [NUM_DIGITS-1:0]         DigitEn,
    input  logic                          LzbEn,
    output logic [3:0]                    BCD,
    output logic [NUM_DIGITS-1:0]         An,
    output logic [$clog2(NUM_DIGITS)-1:0] DigitIdx,
    output logic                          FrameDone
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_LIT  = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [4*NUM_DIGITS-1:0] sh_dig, sh_dig_nxt;
    logic [NUM_DIGITS-1:0]   sh_en, sh_en_nxt;
    logic                    sh_lzb, sh_lzb_nxt;
    logic [NUM_DIGITS-1:0]   visible;
    logic                    hi_zero;
    logic [3:0]              bcd_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;
    logic                    fd_nxt;
    logic                    slot_end, frame_start;

    // A digit is suppressed by LZB when it and every more significant digit are zero;
    // walking from the top keeps a running "all higher digits zero" flag.
    always_comb begin
        hi_zero = 1'b1;
        visible = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            hi_zero    = hi_zero & (sh_dig[4*k +: 4] == 4'd0);
            visible[k] = sh_en[k] & ~(sh_lzb & hi_zero & (k != 0));
        end
    end

    always_comb begin
        slot_end    = cnt == CNT_LAST;
        frame_start = (cnt == '0) && (DigitIdx == '0);
        cnt_nxt     = slot_end ? '0 : cnt + 1'b1;
        idx_nxt     = !slot_end ? DigitIdx : (DigitIdx == IDX_LAST ? '0 : DigitIdx + 1'b1);
        sh_dig_nxt  = frame_start ? Digits  : sh_dig;
        sh_en_nxt   = frame_start ? DigitEn : sh_en;
        sh_lzb_nxt  = frame_start ? LzbEn   : sh_lzb;
        // Visibility is read at the end of the blank window, well after the frame latch settled.
        state_nxt   = (state == SHOW) ? (slot_end ? BLANK : SHOW)
                                      : ((cnt == CNT_LIT && visible[DigitIdx]) ? SHOW : BLANK);
        an_nxt      = (state_nxt == SHOW) ? ~(NUM_DIGITS'(1) << idx_nxt) : '1;
        // Code for the next slot is loaded at the slot boundary so the decoder output has
        // settled throughout the blank window before the anode turns on.
        bcd_nxt     = (state_nxt == SHOW) ? BCD : sh_dig_nxt[4*idx_nxt +: 4];
        fd_nxt      = (idx_nxt == IDX_LAST) && (cnt_nxt == CNT_LAST);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= BLANK;
            cnt       <= '0;
            DigitIdx  <= '0;
            sh_dig    <= '0;
            sh_en     <= '0;
            sh_lzb    <= 1'b0;
            An        <= '1;
            BCD       <= 4'd0;
            FrameDone <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            DigitIdx  <= idx_nxt;
            sh_dig    <= sh_dig_nxt;
            sh_en     <= sh_en_nxt;
            sh_lzb    <= sh_lzb_nxt;
            An        <= an_nxt;
            BCD       <= bcd_nxt;
            FrameDone <= fd_nxt;
        end
    end
endmodule
